sram_2p_march_bist: RTL



---
 rtl/sram_2p_march_bist.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/sram_2p_march_bist.sv
// March C- built-in self-test controller for the 2-port SRAM macro.
//
// While running it owns both BIST ports of the macro. It issues one memory
// operation per cycle, compares the read data one cycle after the macro
// samples each read, and keeps the first miscompare.
//
// Ports
//   CLK, RST            controller clock; synchronous active-high reset
//   START               one-cycle request, accepted only in IDLE
//   BUSY                test in progress (same timing as *_BIST_EN)
//   DONE, FAIL          sticky completion / miscompare flags
//   FAIL_PORT/ELEM/     port (0 = A, 1 = B), march element, address and
//   FAIL_ADDR/DATA      DOUT ^ expected of the first miscompare
//   A_BIST_*, B_BIST_*  registered macro controls; *_BIST_CLK is CLK itself
//   A_DOUT, B_DOUT      macro read data, valid the cycle after a read
//
// March elements (FAIL_ELEM encoding):
//   0 up(w0) A, 1 up(r0,w1) A, 2 up(r1,w0) A, 3 down(r0,w1) A,
//   4 down(r1,w0) A, 5 up(r0) A, 6 up(r0) B
module sram_2p_march_bist #(
   parameter int P_DATA_WIDTH = 20,
   parameter int P_ADDR_WIDTH = 9,
   parameter int P_ADDR_COUNT = 2**P_ADDR_WIDTH
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    START,
   output logic                    BUSY,
   output logic                    DONE,
   output logic                    FAIL,
   output logic                    FAIL_PORT,
   output logic [2:0]              FAIL_ELEM,
   output logic [P_ADDR_WIDTH-1:0] FAIL_ADDR,
   output logic [P_DATA_WIDTH-1:0] FAIL_DATA,
   output logic                    A_BIST_CLK,
   output logic                    A_BIST_EN,
   output logic                    A_BIST_MEN,
   output logic                    A_BIST_WEN,
   output logic                    A_BIST_REN,
   output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
   output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
   output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
   input  logic [P_DATA_WIDTH-1:0] A_DOUT,
   output logic                    B_BIST_CLK,
   output logic                    B_BIST_EN,
   output logic                    B_BIST_MEN,
   output logic                    B_BIST_WEN,
   output logic                    B_BIST_REN,
   output logic [P_ADDR_WIDTH-1:0] B_BIST_ADDR,
   output logic [P_DATA_WIDTH-1:0] B_BIST_DIN,
   output logic [P_DATA_WIDTH-1:0] B_BIST_BM,
   input  logic [P_DATA_WIDTH-1:0] B_DOUT
);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_t;

   localparam logic [P_ADDR_WIDTH-1:0] ADDR_LAST = P_ADDR_WIDTH'(P_ADDR_COUNT - 1);
   localparam logic [P_ADDR_WIDTH-1:0] ADDR_ONE  = {{(P_ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [P_DATA_WIDTH-1:0] DATA_ONES = '1;

   state_t                  state_q, state_d;
   // elem/addr/ph always describe the operation currently on the BIST ports
   logic [2:0]              elem_q, elem_d;
   logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                    ph_q, ph_d;
   logic                    op_vld;

   logic                    two_op_q, down_q, term_q;
   logic                    two_op_d, op_wr, op_port_b, op_ones, a_sel, b_sel;
   logic                    start_acc;

   // One-stage compare pipeline, loaded from the registered port outputs
   logic                    pipe_vld, pipe_port;
   logic [2:0]              pipe_elem;
   logic [P_ADDR_WIDTH-1:0] pipe_addr;
   logic [P_DATA_WIDTH-1:0] pipe_exp, pipe_diff;
   logic                    miscmp;

   assign A_BIST_CLK = CLK;
   assign B_BIST_CLK = CLK;

   assign start_acc = (state_q == ST_IDLE) && START;

   // Properties of the current element: read+write pairs, sweep direction,
   // and explicit terminal address (no reliance on counter wrap-around)
   assign two_op_q = (elem_q >= 3'd1) && (elem_q <= 3'd4);
   assign down_q   = (elem_q == 3'd3) || (elem_q == 3'd4);
   assign term_q   = down_q ? (addr_q == '0) : (addr_q == ADDR_LAST);

   always_comb begin
      state_d = state_q;
      elem_d  = elem_q;
      addr_d  = addr_q;
      ph_d    = ph_q;
      op_vld  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               state_d = ST_RUN;
               elem_d  = 3'd0;
               addr_d  = '0;
               ph_d    = 1'b0;
               op_vld  = 1'b1;
            end
         end
         ST_RUN: begin
            op_vld = 1'b1;
            if (two_op_q && !ph_q) begin
               ph_d = 1'b1;
            end else begin
               ph_d = 1'b0;
               if (term_q) begin
                  if (elem_q == 3'd6) begin
                     state_d = ST_FLUSH;
                     op_vld  = 1'b0;
                  end else begin
                     elem_d = elem_q + 3'd1;
                     // elements 3 and 4 sweep downwards
                     addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_LAST : '0;
                  end
               end else begin
                  addr_d = down_q ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
               end
            end
         end
         ST_FLUSH: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Decode of the operation that will be driven after this edge
   assign two_op_d  = (elem_d >= 3'd1) && (elem_d <= 3'd4);
   assign op_wr     = (elem_d == 3'd0) || (two_op_d && ph_d);
   assign op_port_b = (elem_d == 3'd6);
   assign op_ones   = (elem_d == 3'd1) || (elem_d == 3'd3);
   assign a_sel     = op_vld && !op_port_b;
   assign b_sel     = op_vld && op_port_b;

   assign pipe_diff = (pipe_port ? B_DOUT : A_DOUT) ^ pipe_exp;
   assign miscmp    = pipe_vld && (pipe_diff != '0);

   always_ff @(posedge CLK) begin
      if (RST) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         elem_q      <= '0;
         addr_q      <= '0;
         ph_q        <= 1'b0;
         BUSY        <= 1'b0;
         DONE        <= 1'b0;
         FAIL        <= 1'b0;
         FAIL_PORT   <= 1'b0;
         FAIL_ELEM   <= '0;
         FAIL_ADDR   <= '0;
         FAIL_DATA   <= '0;
         A_BIST_EN   <= 1'b0;
         A_BIST_MEN  <= 1'b0;
         A_BIST_WEN  <= 1'b0;
         A_BIST_REN  <= 1'b0;
         A_BIST_ADDR <= '0;
         A_BIST_DIN  <= '0;
         A_BIST_BM   <= '0;
         B_BIST_EN   <= 1'b0;
         B_BIST_MEN  <= 1'b0;
         B_BIST_WEN  <= 1'b0;
         B_BIST_REN  <= 1'b0;
         B_BIST_ADDR <= '0;
         B_BIST_DIN  <= '0;
         B_BIST_BM   <= '0;
         pipe_vld    <= 1'b0;
         pipe_port   <= 1'b0;
         pipe_elem   <= '0;
         pipe_addr   <= '0;
         pipe_exp    <= '0;
      end else begin
         elem_q      <= elem_d;
         addr_q      <= addr_d;
         ph_q        <= ph_d;
         BUSY        <= (state_d != ST_IDLE);
         A_BIST_EN   <= (state_d != ST_IDLE);
         B_BIST_EN   <= (state_d != ST_IDLE);
         A_BIST_MEN  <= a_sel;
         A_BIST_WEN  <= a_sel && op_wr;
         A_BIST_REN  <= a_sel && !op_wr;
         A_BIST_ADDR <= a_sel ? addr_d : '0;
         A_BIST_DIN  <= (a_sel && op_wr && op_ones) ? DATA_ONES : '0;
         A_BIST_BM   <= (a_sel && op_wr) ? DATA_ONES : '0;
         B_BIST_MEN  <= b_sel;
         B_BIST_WEN  <= b_sel && op_wr;
         B_BIST_REN  <= b_sel && !op_wr;
         B_BIST_ADDR <= b_sel ? addr_d : '0;
         B_BIST_DIN  <= (b_sel && op_wr && op_ones) ? DATA_ONES : '0;
         B_BIST_BM   <= (b_sel && op_wr) ? DATA_ONES : '0;
         // The macro samples the current read at this edge; its data is
         // compared at the next edge against the word recorded here.
         pipe_vld    <= A_BIST_REN || B_BIST_REN;
         pipe_port   <= B_BIST_REN;
         pipe_elem   <= elem_q;
         pipe_addr   <= B_BIST_REN ? B_BIST_ADDR : A_BIST_ADDR;
         pipe_exp    <= ((elem_q == 3'd2) || (elem_q == 3'd4)) ? DATA_ONES : '0;
         if (start_acc) begin
            DONE      <= 1'b0;
            FAIL      <= 1'b0;
            FAIL_PORT <= 1'b0;
            FAIL_ELEM <= '0;
            FAIL_ADDR <= '0;
            FAIL_DATA <= '0;
         end else begin
            if (state_q == ST_FLUSH) DONE <= 1'b1;
            if (miscmp && !FAIL) begin
               FAIL      <= 1'b1;
               FAIL_PORT <= pipe_port;
               FAIL_ELEM <= pipe_elem;
               FAIL_ADDR <= pipe_addr;
               FAIL_DATA <= pipe_diff;
            end
         end
      end
   end

endmodule
